// File: rtl/pmp_frame_seq.sv
// pmp_frame_seq: buffers three phase-shift frames and emits aligned 4-pixel tuples while the fourth frame streams in.
module pmp_frame_seq #(
    parameter int FRAME_PIXELS = 512,
    parameter int AW = $clog2(FRAME_PIXELS)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       abort_i,
    input  logic       vld_i,
    input  logic [7:0] pixel_i,
    input  logic       last_i,
    output logic       vld_o,
    output logic [7:0] pixel1_o,
    output logic [7:0] pixel2_o,
    output logic [7:0] pixel3_o,
    output logic [7:0] pixel4_o,
    output logic       last_o,
    output logic [1:0] state_o,
    output logic       err_o
);
    typedef enum logic [1:0] {F1, F2, F3, F4} state_t;
    localparam logic [AW-1:0] LAST = AW'(FRAME_PIXELS - 1);
    state_t state, state_nx;
    logic [AW-1:0] idx, idx_nx;
    logic drop, drop_nx, err_nx, last_q;
    logic acc, at_end, fend, bad, rd;
    logic [1:0] rst_q;
    logic rst_int_n;
    logic [7:0] b1 [FRAME_PIXELS];
    logic [7:0] b2 [FRAME_PIXELS];
    logic [7:0] b3 [FRAME_PIXELS];
    // reset asserts immediately but releases only after two clean edges
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_q <= 2'b00;
        else rst_q <= {rst_q[0], 1'b1};
    assign rst_int_n = rst_q[1];
    assign acc = vld_i & ~abort_i & ~drop;
    assign at_end = idx == LAST;
    assign fend = acc & (last_i | at_end);
    assign bad = fend & ~(last_i & at_end);
    assign rd = acc & (state == F4);
    assign state_o = state;
    assign last_o = last_q & ~abort_i;
    always_comb begin
        state_nx = state;
        idx_nx = idx;
        drop_nx = drop;
        err_nx = err_o;
        if (abort_i) begin
            state_nx = F1;
            idx_nx = '0;
            drop_nx = 1'b0;
            err_nx = 1'b0;
        end else if (drop) begin
            drop_nx = ~(vld_i & last_i);
        end else if (fend) begin
            idx_nx = '0;
            state_nx = bad ? F1 : state_t'(state + 2'd1);
            err_nx = err_o | bad;
            drop_nx = ~last_i;
        end else if (acc) begin
            idx_nx = idx + AW'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_int_n)
        if (!rst_int_n) begin
            state <= F1;
            idx <= '0;
            drop <= 1'b0;
            err_o <= 1'b0;
        end else begin
            state <= state_nx;
            idx <= idx_nx;
            drop <= drop_nx;
            err_o <= err_nx;
        end
    // frame buffers are never cleared; F4 is only reached after all three are rewritten
    always_ff @(posedge clk) begin
        if (acc && state == F1) b1[idx] <= pixel_i;
        if (acc && state == F2) b2[idx] <= pixel_i;
        if (acc && state == F3) b3[idx] <= pixel_i;
    end
    always_ff @(posedge clk or negedge rst_int_n)
        if (!rst_int_n) begin
            vld_o <= 1'b0;
            last_q <= 1'b0;
            pixel1_o <= '0;
            pixel2_o <= '0;
            pixel3_o <= '0;
            pixel4_o <= '0;
        end else begin
            vld_o <= rd;
            last_q <= rd & fend;
            if (rd) begin
                pixel1_o <= b1[idx];
                pixel2_o <= b2[idx];
                pixel3_o <= b3[idx];
                pixel4_o <= pixel_i;
            end
        end
endmodule
